// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage -- execute stage of the integer pipeline.
//
// Takes the decoded instruction (operation code, operand-B source select,
// operands and write controls), computes the logical/shift/move-from-HI/LO
// result combinationally, and captures it in the EX/MEM pipeline register
// one cycle later. The stage also owns the HI and LO special registers.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid                 decode outputs carry a real instruction
//   stall, flush             hazard-unit control (stall has priority)
//   instr_type[1:0]          operand-B select (R-type: rdata2, else ext_imm)
//   aluop[3:0]               operation code (see ALUOP_* below)
//   ext_imm[31:0]            extended immediate / shift amount
//   rdata1[31:0]             operand A
//   rdata2[31:0]             operand B register value
//   waddr[4:0]               destination GPR
//   reg_wr, mem_wr           GPR / memory write requests
//   to_hi, to_lo             write (A|B) into HI / LO
//   ex_valid, ex_reg_wr, ex_waddr, ex_wdata, ex_mem_wr
//                            EX/MEM pipeline register outputs
//   hi_o, lo_o               current HI / LO contents
//
// Encodings
//   instr_type: 2'd0 = I-type, 2'd1 = R-type, others behave as I-type.
//   aluop     : 0 and, 1 or, 2 xor, 3 nor, 4 sll, 5 srl, 6 sra,
//               7 mfhi, 8 mflo, anything else yields zero.
// ---------------------------------------------------------------------------
module ex_stage #(
    parameter logic [31:0] HI_RST = 32'h0,
    parameter logic [31:0] LO_RST = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        stall,
    input  logic        flush,
    input  logic [1:0]  instr_type,
    input  logic [3:0]  aluop,
    input  logic [31:0] ext_imm,
    input  logic [31:0] rdata1,
    input  logic [31:0] rdata2,
    input  logic [4:0]  waddr,
    input  logic        reg_wr,
    input  logic        mem_wr,
    input  logic        to_hi,
    input  logic        to_lo,
    output logic        ex_valid,
    output logic        ex_reg_wr,
    output logic [4:0]  ex_waddr,
    output logic [31:0] ex_wdata,
    output logic        ex_mem_wr,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam logic [1:0] TYPE_R      = 2'd1;

    localparam logic [3:0] ALUOP_AND   = 4'd0;
    localparam logic [3:0] ALUOP_OR    = 4'd1;
    localparam logic [3:0] ALUOP_XOR   = 4'd2;
    localparam logic [3:0] ALUOP_NOR   = 4'd3;
    localparam logic [3:0] ALUOP_SLL   = 4'd4;
    localparam logic [3:0] ALUOP_SRL   = 4'd5;
    localparam logic [3:0] ALUOP_SRA   = 4'd6;
    localparam logic [3:0] ALUOP_MFHI  = 4'd7;
    localparam logic [3:0] ALUOP_MFLO  = 4'd8;

    logic [31:0] hi_reg;
    logic [31:0] lo_reg;

    logic        ex_valid_reg;
    logic        ex_reg_wr_reg;
    logic [4:0]  ex_waddr_reg;
    logic [31:0] ex_wdata_reg;
    logic        ex_mem_wr_reg;

    logic [31:0] opb;
    logic [4:0]  shamt;
    logic [31:0] or_ab;
    logic [31:0] result_next;
    logic        fire;

    // Only R-type selects the register operand; every other type code
    // (including the unused ones) takes the immediate.
    assign opb   = (instr_type == TYPE_R) ? rdata2 : ext_imm;
    assign shamt = opb[4:0];
    assign fire  = in_valid & ~stall & ~flush;

    // Bitwise OR is shared between the ALU and the HI/LO write path.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_or
            assign or_ab[gi] = rdata1[gi] | opb[gi];
        end
    endgenerate

    always_comb begin
        result_next = 32'h0;
        case (aluop)
            ALUOP_AND:  result_next = rdata1 & opb;
            ALUOP_OR:   result_next = or_ab;
            ALUOP_XOR:  result_next = rdata1 ^ opb;
            ALUOP_NOR:  result_next = ~or_ab;
            ALUOP_SLL:  result_next = rdata1 << shamt;
            ALUOP_SRL:  result_next = rdata1 >> shamt;
            ALUOP_SRA:  result_next = $unsigned($signed(rdata1) >>> shamt);
            // Reads the register itself: an mthi/mtlo in the previous cycle
            // has already landed, so no bypass is needed.
            ALUOP_MFHI: result_next = hi_reg;
            ALUOP_MFLO: result_next = lo_reg;
            default:    result_next = 32'h0;
        endcase
    end

    // EX/MEM pipeline register. Stall holds everything and takes priority
    // over flush; a flush inserts a bubble with zeroed address/data.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_reg  <= 1'b0;
            ex_reg_wr_reg <= 1'b0;
            ex_waddr_reg  <= 5'd0;
            ex_wdata_reg  <= 32'h0;
            ex_mem_wr_reg <= 1'b0;
        end else if (!stall) begin
            if (flush) begin
                ex_valid_reg  <= 1'b0;
                ex_reg_wr_reg <= 1'b0;
                ex_waddr_reg  <= 5'd0;
                ex_wdata_reg  <= 32'h0;
                ex_mem_wr_reg <= 1'b0;
            end else begin
                ex_valid_reg  <= in_valid;
                // r0 is hard-wired zero, so a write to it is dropped here.
                ex_reg_wr_reg <= reg_wr & in_valid & (waddr != 5'd0);
                ex_waddr_reg  <= waddr;
                ex_wdata_reg  <= result_next;
                ex_mem_wr_reg <= mem_wr & in_valid;
            end
        end
    end

    // HI/LO update only for an instruction that actually advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_reg <= HI_RST;
            lo_reg <= LO_RST;
        end else if (fire) begin
            if (to_hi) hi_reg <= or_ab;
            if (to_lo) lo_reg <= or_ab;
        end
    end

    assign ex_valid  = ex_valid_reg;
    assign ex_reg_wr = ex_reg_wr_reg;
    assign ex_waddr  = ex_waddr_reg;
    assign ex_wdata  = ex_wdata_reg;
    assign ex_mem_wr = ex_mem_wr_reg;
    assign hi_o      = hi_reg;
    assign lo_o      = lo_reg;

endmodule

// File: tb/tb_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_stage -- self-checking bench for ex_stage.
// A behavioural model (plain arithmetic on the instruction semantics) is
// advanced once per clock; every cycle all DUT outputs are compared to it.
// Directed scenarios add hand-computed literal expectations, followed by a
// randomized run.
// ---------------------------------------------------------------------------
module tb_ex_stage;

    localparam logic [31:0] HI_RST = 32'h1111_0000;
    localparam logic [31:0] LO_RST = 32'h0000_2222;

    localparam logic [1:0] T_I = 2'd0;
    localparam logic [1:0] T_R = 2'd1;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_NOR  = 4'd3;
    localparam logic [3:0] OP_SLL  = 4'd4;
    localparam logic [3:0] OP_SRL  = 4'd5;
    localparam logic [3:0] OP_SRA  = 4'd6;
    localparam logic [3:0] OP_MFHI = 4'd7;
    localparam logic [3:0] OP_MFLO = 4'd8;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        stall;
    logic        flush;
    logic [1:0]  instr_type;
    logic [3:0]  aluop;
    logic [31:0] ext_imm;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [4:0]  waddr;
    logic        reg_wr;
    logic        mem_wr;
    logic        to_hi;
    logic        to_lo;
    logic        ex_valid;
    logic        ex_reg_wr;
    logic [4:0]  ex_waddr;
    logic [31:0] ex_wdata;
    logic        ex_mem_wr;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // model state
    logic        m_valid, m_reg_wr, m_mem_wr;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata, m_hi, m_lo;

    ex_stage #(.HI_RST(HI_RST), .LO_RST(LO_RST)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
        .instr_type(instr_type), .aluop(aluop), .ext_imm(ext_imm),
        .rdata1(rdata1), .rdata2(rdata2), .waddr(waddr), .reg_wr(reg_wr),
        .mem_wr(mem_wr), .to_hi(to_hi), .to_lo(to_lo),
        .ex_valid(ex_valid), .ex_reg_wr(ex_reg_wr), .ex_waddr(ex_waddr),
        .ex_wdata(ex_wdata), .ex_mem_wr(ex_mem_wr), .hi_o(hi_o), .lo_o(lo_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Instruction semantics at the ISA level.
    function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] hi,
                                              input logic [31:0] lo);
        int sh;
        longint sa;
        sh = int'(b % 32);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            OP_SLL:  return a << sh;
            OP_SRL:  return a >> sh;
            OP_SRA: begin
                // sign-extend to 64 bits, divide by a power of two rounding down
                sa = longint'($signed(a));
                sa = (sa - ((sa < 0) ? ((64'sd1 <<< sh) - 1) : 0)) / (64'sd1 <<< sh);
                return sa[31:0];
            end
            OP_MFHI: return hi;
            OP_MFLO: return lo;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_edge();
        logic [31:0] b, res;
        if (rst) begin
            m_valid = 0; m_reg_wr = 0; m_mem_wr = 0; m_waddr = 0; m_wdata = 0;
            m_hi = HI_RST; m_lo = LO_RST;
            return;
        end
        b   = (instr_type == T_R) ? rdata2 : ext_imm;
        res = alu_model(aluop, rdata1, b, m_hi, m_lo);
        if (in_valid && !stall && !flush) begin
            if (to_hi) m_hi = rdata1 | b;
            if (to_lo) m_lo = rdata1 | b;
        end
        if (!stall) begin
            if (flush) begin
                m_valid = 0; m_reg_wr = 0; m_mem_wr = 0; m_waddr = 0; m_wdata = 0;
            end else begin
                m_valid  = in_valid;
                m_reg_wr = in_valid && reg_wr && (waddr != 0);
                m_mem_wr = in_valid && mem_wr;
                m_waddr  = waddr;
                m_wdata  = res;
            end
        end
    endtask

    task automatic compare_all();
        check("ex_valid",  {31'b0, ex_valid},  {31'b0, m_valid});
        check("ex_reg_wr", {31'b0, ex_reg_wr}, {31'b0, m_reg_wr});
        check("ex_mem_wr", {31'b0, ex_mem_wr}, {31'b0, m_mem_wr});
        check("ex_waddr",  {27'b0, ex_waddr},  {27'b0, m_waddr});
        check("ex_wdata",  ex_wdata, m_wdata);
        check("hi_o",      hi_o, m_hi);
        check("lo_o",      lo_o, m_lo);
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        compare_all();
    endtask

    task automatic set_in(input logic [1:0] t, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] imm, input logic [4:0] wa,
                          input logic rw, input logic th, input logic tl);
        in_valid = 1; stall = 0; flush = 0; rst = 0;
        instr_type = t; aluop = op; rdata1 = a; rdata2 = b; ext_imm = imm;
        waddr = wa; reg_wr = rw; mem_wr = 0; to_hi = th; to_lo = tl;
    endtask

    logic [31:0] held;

    initial begin
        m_valid = 0; m_reg_wr = 0; m_mem_wr = 0; m_waddr = 0; m_wdata = 0;
        m_hi = 0; m_lo = 0;
        set_in(T_I, OP_AND, 0, 0, 0, 0, 0, 0, 0);
        in_valid = 0;
        rst = 1;
        @(negedge clk);

        // 1. reset
        step(); step();
        check("rst_valid", {31'b0, ex_valid}, 32'd0);
        check("rst_wdata", ex_wdata, 32'h0);
        check("rst_hi", hi_o, 32'h1111_0000);
        check("rst_lo", lo_o, 32'h0000_2222);

        // 2. ori
        set_in(T_I, OP_OR, 32'h0000_1200, 32'hFFFF_FFFF, 32'h0000_0034, 5'd5, 1, 0, 0);
        step();
        check("ori_wdata", ex_wdata, 32'h0000_1234);
        check("ori_waddr", {27'b0, ex_waddr}, 32'd5);
        check("ori_regwr", {31'b0, ex_reg_wr}, 32'd1);

        // 3. shifts
        set_in(T_I, OP_SRA, 32'h8000_0000, 0, 32'h0000_0004, 5'd6, 1, 0, 0);
        step();
        check("sra_wdata", ex_wdata, 32'hF800_0000);
        set_in(T_R, OP_SRL, 32'h8000_0000, 32'h0000_0024, 32'h0000_001F, 5'd7, 1, 0, 0);
        step();
        check("srlv_wdata", ex_wdata, 32'h0800_0000);

        // 4. HI/LO
        set_in(T_R, OP_OR, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd0, 0, 1, 0);
        step();
        set_in(T_R, OP_MFHI, 32'h0, 32'h0, 32'h0, 5'd8, 1, 0, 0);
        step();
        check("mfhi_wdata", ex_wdata, 32'hDEAD_BEEF);
        set_in(T_R, OP_OR, 32'h1234_5678, 32'h0, 32'h0, 5'd0, 0, 1, 1);
        stall = 1;
        step();
        check("mthi_stalled", hi_o, 32'hDEAD_BEEF);

        // 5. stall / flush
        set_in(T_I, OP_XOR, 32'hA5A5_0000, 0, 32'h0000_5A5A, 5'd9, 1, 0, 0);
        step();
        held = ex_wdata;
        check("xor_wdata", held, 32'hA5A5_5A5A);
        set_in(T_I, OP_NOR, 32'h0, 0, 32'h0, 5'd10, 1, 0, 0);
        stall = 1;
        step(); step(); step();
        check("stall_wdata", ex_wdata, 32'hA5A5_5A5A);
        check("stall_waddr", {27'b0, ex_waddr}, 32'd9);
        stall = 0; flush = 1;
        step();
        check("flush_valid", {31'b0, ex_valid}, 32'd0);
        check("flush_regwr", {31'b0, ex_reg_wr}, 32'd0);
        set_in(T_I, OP_OR, 32'h0, 0, 32'h0000_0077, 5'd11, 1, 0, 0);
        step();
        stall = 1; flush = 1;
        step();
        check("stallflush_valid", {31'b0, ex_valid}, 32'd1);
        check("stallflush_wdata", ex_wdata, 32'h0000_0077);

        // 6. r0 write, reset while stalled
        set_in(T_I, OP_OR, 32'h0, 0, 32'h0000_0001, 5'd0, 1, 0, 0);
        step();
        check("r0_regwr", {31'b0, ex_reg_wr}, 32'd0);
        check("r0_valid", {31'b0, ex_valid}, 32'd1);
        stall = 1; rst = 1;
        step();
        check("rststall_valid", {31'b0, ex_valid}, 32'd0);
        check("rststall_hi", hi_o, 32'h1111_0000);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            rst        = ($urandom_range(0, 99) == 0);
            in_valid   = ($urandom_range(0, 3) != 0);
            stall      = ($urandom_range(0, 7) == 0);
            flush      = ($urandom_range(0, 7) == 0);
            instr_type = 2'($urandom_range(0, 3));
            aluop      = 4'($urandom_range(0, 10));
            rdata1     = $urandom;
            rdata2     = $urandom;
            ext_imm    = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 63));
            waddr      = 5'($urandom_range(0, 31));
            reg_wr     = 1'($urandom_range(0, 1));
            mem_wr     = 1'($urandom_range(0, 1));
            to_hi      = ($urandom_range(0, 4) == 0);
            to_lo      = ($urandom_range(0, 4) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
